// File: rtl/tpu_layer_sequencer.sv
// Layer sequencer for the TPU datapath: load weights, switch the array, then
// stream bias and inputs from the unified buffer and wait out the pipeline drain.
module tpu_layer_sequencer #(
  parameter int N            = 2,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_w_addr,
  input  logic [15:0] cmd_x_addr,
  input  logic [15:0] cmd_b_addr,
  input  logic [15:0] cmd_rows,
  input  logic [15:0] cmd_cols,
  input  logic [3:0]  cmd_pathway,
  input  logic        abort,
  output logic        ub_rd_start_out,
  output logic [8:0]  ub_ptr_select_out,
  output logic [15:0] ub_rd_addr_out,
  output logic [15:0] ub_rd_count_out,
  output logic        sys_switch_out,
  output logic [3:0]  vpu_data_pathway_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (N < 1) begin : g_n_check
    $error("tpu_layer_sequencer: N must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, W_ISSUE, W_WAIT, SWITCH, B_ISSUE, X_ISSUE, X_WAIT, DONE
  } state_t;

  state_t state, next_state;

  logic [15:0] x_addr, b_addr, rows, cols;
  logic [3:0]  pathway;
  logic [15:0] w_cnt;
  logic [16:0] x_cnt;

  logic        n_start, n_switch, n_busy, n_done, n_err;
  logic [8:0]  n_ptr;
  logic [15:0] n_addr, n_count;
  logic [3:0]  n_path;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid)
                 next_state = (cmd_rows == 16'd0 || cmd_cols == 16'd0) ? DONE : W_ISSUE;
      W_ISSUE: next_state = W_WAIT;
      W_WAIT:  if (w_cnt == 16'd1) next_state = SWITCH;
      SWITCH:  next_state = B_ISSUE;
      B_ISSUE: next_state = X_ISSUE;
      X_ISSUE: next_state = X_WAIT;
      X_WAIT:  if (x_cnt == 17'd1) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (state != IDLE && abort) next_state = IDLE;
  end

  // Outputs are registered, so they are decoded from the state being entered.
  // W_ISSUE is only entered from IDLE, so it takes the command fields directly.
  always_comb begin
    n_start  = 1'b0;
    n_ptr    = 9'd0;
    n_addr   = 16'd0;
    n_count  = 16'd0;
    n_switch = 1'b0;
    n_done   = 1'b0;
    n_err    = 1'b0;
    n_busy   = (next_state != IDLE);
    n_path   = 4'd0;
    if (next_state != IDLE) n_path = (state == IDLE) ? cmd_pathway : pathway;
    case (next_state)
      W_ISSUE: begin
        n_start = 1'b1; n_ptr = 9'd1; n_addr = cmd_w_addr; n_count = cmd_cols;
      end
      SWITCH:  n_switch = 1'b1;
      B_ISSUE: begin
        n_start = 1'b1; n_ptr = 9'd2; n_addr = b_addr; n_count = rows;
      end
      X_ISSUE: begin
        n_start = 1'b1; n_ptr = 9'd0; n_addr = x_addr; n_count = rows;
      end
      DONE: begin
        n_done = 1'b1;
        n_err  = (state == IDLE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      x_addr               <= 16'd0;
      b_addr               <= 16'd0;
      rows                 <= 16'd0;
      cols                 <= 16'd0;
      pathway              <= 4'd0;
      w_cnt                <= 16'd0;
      x_cnt                <= 17'd0;
      ub_rd_start_out      <= 1'b0;
      ub_ptr_select_out    <= 9'd0;
      ub_rd_addr_out       <= 16'd0;
      ub_rd_count_out      <= 16'd0;
      sys_switch_out       <= 1'b0;
      vpu_data_pathway_out <= 4'd0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && cmd_valid) begin
        x_addr  <= cmd_x_addr;
        b_addr  <= cmd_b_addr;
        rows    <= cmd_rows;
        cols    <= cmd_cols;
        pathway <= cmd_pathway;
      end
      if (state == W_ISSUE)     w_cnt <= cols;
      else if (state == W_WAIT) w_cnt <= w_cnt - 16'd1;
      // 17 bits so rows=0xFFFF plus the drain does not wrap.
      if (state == X_ISSUE)     x_cnt <= {1'b0, rows} + 17'(DRAIN_CYCLES);
      else if (state == X_WAIT) x_cnt <= x_cnt - 17'd1;
      ub_rd_start_out      <= n_start;
      ub_ptr_select_out    <= n_ptr;
      ub_rd_addr_out       <= n_addr;
      ub_rd_count_out      <= n_count;
      sys_switch_out       <= n_switch;
      vpu_data_pathway_out <= n_path;
      busy                 <= n_busy;
      done                 <= n_done;
      err                  <= n_err;
    end
  end

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Bench for tpu_layer_sequencer: a command timeline model fills an expected
// queue of per-cycle output vectors that the DUT is compared against.
module tb_tpu_layer_sequencer;

  localparam int DRAIN = 6;
  localparam int W     = 51;

  logic        clk, rst, cmd_valid, cmd_ready, abort;
  logic [15:0] cmd_w_addr, cmd_x_addr, cmd_b_addr, cmd_rows, cmd_cols;
  logic [3:0]  cmd_pathway;
  logic        ub_rd_start_out, sys_switch_out, busy, done, err;
  logic [8:0]  ub_ptr_select_out;
  logic [15:0] ub_rd_addr_out, ub_rd_count_out;
  logic [3:0]  vpu_data_pathway_out;

  typedef struct {
    logic [15:0] w, x, b, rows, cols;
    logic [3:0]  path;
    bit          scramble;
    int          abort_at;   // -1 none, 0 = together with the offer, k = during Ck
    int          exp_done;   // cycle of done relative to acceptance, -1 none
    bit          exp_err;
  } vec_t;

  vec_t        vecs[9];
  logic [W-1:0] exp_q[$];
  int          checks, errors;

  tpu_layer_sequencer #(.N(2), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_addr(cmd_w_addr), .cmd_x_addr(cmd_x_addr), .cmd_b_addr(cmd_b_addr),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_pathway(cmd_pathway),
    .abort(abort), .ub_rd_start_out(ub_rd_start_out),
    .ub_ptr_select_out(ub_ptr_select_out), .ub_rd_addr_out(ub_rd_addr_out),
    .ub_rd_count_out(ub_rd_count_out), .sys_switch_out(sys_switch_out),
    .vpu_data_pathway_out(vpu_data_pathway_out), .busy(busy), .done(done),
    .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input logic rdy, input logic st,
      input logic [8:0] ptr, input logic [15:0] addr, input logic [15:0] cnt,
      input logic sw, input logic [3:0] path, input logic bsy, input logic dn,
      input logic er);
    return {rdy, st, ptr, addr, cnt, sw, path, bsy, dn, er};
  endfunction

  function automatic logic [W-1:0] actual_vec();
    return pack(cmd_ready, ub_rd_start_out, ub_ptr_select_out, ub_rd_addr_out,
                ub_rd_count_out, sys_switch_out, vpu_data_pathway_out, busy, done, err);
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return pack(1'b1, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t mk(input logic [15:0] w, input logic [15:0] x,
      input logic [15:0] b, input logic [15:0] rows, input logic [15:0] cols,
      input logic [3:0] path, input bit scr, input int ab, input int ed, input bit ee);
    vec_t v;
    v.w = w; v.x = x; v.b = b; v.rows = rows; v.cols = cols; v.path = path;
    v.scramble = scr; v.abort_at = ab; v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  // Timeline of a layer: weight read at C1, cols wait cycles, switch, bias
  // read, input read, rows+DRAIN wait cycles, done; then idle.
  function automatic void build_trace(input vec_t v);
    logic [W-1:0] busy_v;
    busy_v = pack(1'b0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0, v.path, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    if (v.rows == 16'd0 || v.cols == 16'd0) begin
      exp_q.push_back(pack(1'b0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0, v.path, 1'b1, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(pack(1'b0, 1'b1, 9'd1, v.w, v.cols, 1'b0, v.path, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < int'(v.cols); i++) exp_q.push_back(busy_v);
      exp_q.push_back(pack(1'b0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b1, v.path, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(pack(1'b0, 1'b1, 9'd2, v.b, v.rows, 1'b0, v.path, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(pack(1'b0, 1'b1, 9'd0, v.x, v.rows, 1'b0, v.path, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < int'(v.rows) + DRAIN; i++) exp_q.push_back(busy_v);
      exp_q.push_back(pack(1'b0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0, v.path, 1'b1, 1'b1, 1'b0));
    end
    // An abort during Ck leaves C1..Ck intact and returns to idle at Ck+1.
    if (v.abort_at >= 1 && v.abort_at < exp_q.size())
      while (exp_q.size() > v.abort_at) void'(exp_q.pop_back());
    exp_q.push_back(idle_vec());
  endfunction

  // scoreboard helpers
  task automatic check_vec(input string name, input int k, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // drivers
  task automatic drive_fields(input vec_t v);
    cmd_w_addr = v.w; cmd_x_addr = v.x; cmd_b_addr = v.b;
    cmd_rows = v.rows; cmd_cols = v.cols; cmd_pathway = v.path;
  endtask

  task automatic scramble_fields();
    cmd_w_addr = 16'($urandom); cmd_x_addr = 16'($urandom); cmd_b_addr = 16'($urandom);
    cmd_rows = 16'($urandom); cmd_cols = 16'($urandom); cmd_pathway = 4'($urandom);
  endtask

  task automatic run_cmd(input vec_t v, input bit preoffered, input bit hold_next,
                         input vec_t nv, output int done_at, output bit err_seen);
    int k;
    if (!preoffered) begin
      @(negedge clk);
      drive_fields(v);
      cmd_valid = 1'b1;
      abort = (v.abort_at == 0);
    end
    check_int("ready_at_offer", int'(cmd_ready), 1);
    @(posedge clk);
    build_trace(v);
    done_at = -1; err_seen = 1'b0; k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      check_vec("trace", k, actual_vec(), exp_q.pop_front());
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (err === 1'b1) err_seen = 1'b1;
      abort = (k == v.abort_at);
      if (hold_next) begin
        drive_fields(nv);
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
        if (v.scramble) scramble_fields();
      end
    end
  endtask

  initial begin
    vec_t v, nv;
    int d, lat;
    bit e;
    checks = 0; errors = 0;
    rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    cmd_w_addr = 16'd0; cmd_x_addr = 16'd0; cmd_b_addr = 16'd0;
    cmd_rows = 16'd0; cmd_cols = 16'd0; cmd_pathway = 4'd0;

    vecs[0] = mk(16'h10, 16'h40, 16'h30, 16'd3, 16'd2, 4'b0101, 0, -1, 16, 0);
    vecs[1] = mk(16'h10, 16'h40, 16'h30, 16'd3, 16'd2, 4'b0101, 1, -1, 16, 0);
    vecs[2] = mk(16'h11, 16'h22, 16'h33, 16'd0, 16'd5, 4'b1010, 0, -1, 1, 1);
    vecs[3] = mk(16'h11, 16'h22, 16'h33, 16'd4, 16'd0, 4'b0011, 0, -1, 1, 1);
    vecs[4] = mk(16'hAAAA, 16'h5555, 16'hFFFF, 16'd1, 16'd1, 4'b1111, 1, -1, 13, 0);
    vecs[5] = mk(16'h0100, 16'h0200, 16'h0300, 16'hFFFF, 16'd1, 4'b0110, 0, -1, 65547, 0);
    vecs[6] = mk(16'h10, 16'h40, 16'h30, 16'd3, 16'd2, 4'b0101, 0, 3, -1, 0);
    vecs[7] = mk(16'h10, 16'h40, 16'h30, 16'd3, 16'd2, 4'b0101, 0, 0, 16, 0);
    vecs[8] = mk(16'h10, 16'h40, 16'h30, 16'd3, 16'd2, 4'b0101, 0, 15, -1, 0);

    // reset holds idle even with a command offered
    drive_fields(vecs[0]);
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("reset_hold", 0, actual_vec(), idle_vec());
    cmd_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i], 1'b0, 1'b0, vecs[i], d, e);
      check_int($sformatf("done_cycle_%0d", i), d, vecs[i].exp_done);
      check_int($sformatf("err_flag_%0d", i), int'(e), int'(vecs[i].exp_err));
    end

    // back-to-back: second command held valid throughout the first
    nv = mk(16'h0500, 16'h0600, 16'h0700, 16'd2, 16'd3, 4'b1001, 0, -1, 16, 0);
    run_cmd(vecs[0], 1'b0, 1'b1, nv, d, e);
    check_int("b2b_first_done", d, 16);
    run_cmd(nv, 1'b1, 1'b0, nv, d, e);
    check_int("b2b_second_done", d, 16);

    // reset asserted during C8 of the nominal command
    @(negedge clk);
    drive_fields(vecs[0]);
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_vec("reset_mid_immediate", 8, actual_vec(), idle_vec());
    @(negedge clk);
    check_vec("reset_mid_held", 9, actual_vec(), idle_vec());
    rst = 1'b1;
    drive_fields(vecs[0]);
    cmd_valid = 1'b1;
    run_cmd(vecs[0], 1'b1, 1'b0, vecs[0], d, e);
    check_int("after_reset_done", d, 16);

    // randomized commands against the timeline model
    for (int r = 0; r < 30; r++) begin
      v = mk(16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom_range(0, 9)), 16'($urandom_range(0, 9)),
             4'($urandom), bit'($urandom_range(0, 1)), -1, 0, 0);
      if (v.rows == 16'd0 || v.cols == 16'd0) lat = 1;
      else lat = 5 + int'(v.cols) + int'(v.rows) + DRAIN;
      if (lat > 1 && $urandom_range(0, 3) == 0) v.abort_at = $urandom_range(1, lat - 1);
      run_cmd(v, 1'b0, 1'b0, v, d, e);
      check_int($sformatf("rand_done_%0d", r), d, (v.abort_at > 0) ? -1 : lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_layer_sequencer.md
TPU_LAYER_SEQUENCER -- requirements
Module: tpu_layer_sequencer

Interface
REQ-001 SHALL have parameter N, default 2, meaning systolic array width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 6, meaning post-stream cycles allowed for systolic, VPU and deskew flush.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  layer command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_w_addr  in  16  UB weight base address.
- cmd_x_addr  in  16  UB input base address.
- cmd_b_addr  in  16  UB bias base address.
- cmd_rows  in  16  input vectors to stream.
- cmd_cols  in  16  weight rows to load.
- cmd_pathway  in  4  VPU pathway for this layer.
- abort  in  1  cancel the current command.
- ub_rd_start_out  out  1  UB read start pulse.
- ub_ptr_select_out  out  9  UB pointer: 0 input, 1 weight, 2 bias.
- ub_rd_addr_out  out  16  UB read address.
- ub_rd_count_out  out  16  UB read length.
- sys_switch_out  out  1  weight-switch pulse to the array.
- vpu_data_pathway_out  out  4  VPU pathway.
- busy  out  1  command in progress.
- done  out  1  command complete pulse.
- err  out  1  zero-length command pulse, coincident with done.

Function
REQ-004 SHALL use states IDLE, W_ISSUE, W_WAIT, SWITCH, B_ISSUE, X_ISSUE, X_WAIT, DONE.
REQ-005 SHALL drive cmd_ready=1 only in IDLE; acceptance is cmd_valid&&cmd_ready at a rising edge, at cycle C0.
REQ-006 SHALL latch all cmd_* fields on acceptance; later changes to cmd_* SHALL be ignored until the next acceptance.
REQ-007 W_ISSUE (C1): start=1, ptr=1, addr=w_addr, count=cols; the next state SHALL be W_WAIT.
REQ-008 W_WAIT SHALL last exactly cols cycles (C2..C1+cols), with a 16-bit down-counter; the next state SHALL be SWITCH.
REQ-009 SWITCH (C2+cols): sys_switch_out=1 for exactly one cycle.
REQ-010 B_ISSUE (C3+cols): start=1, ptr=2, addr=b_addr, count=rows.
REQ-011 X_ISSUE (C4+cols): start=1, ptr=0, addr=x_addr, count=rows.
REQ-012 X_WAIT SHALL last rows+DRAIN_CYCLES cycles.
- The counter SHALL be 17 bits wide so that rows=0xFFFF does not wrap.
REQ-013 DONE (C5+cols+rows+DRAIN_CYCLES):
- done=1 for one cycle.
- The next state SHALL be IDLE.
- cmd_ready SHALL be 1 on the following cycle.
REQ-014 ub_rd_start_out SHALL be high on at most one cycle per issue state.
- It SHALL never be high on two consecutive cycles except B_ISSUE→X_ISSUE.
- It SHALL never be high outside the issue states.
REQ-015 ptr, addr and count SHALL be 0 whenever ub_rd_start_out=0.
REQ-016 vpu_data_pathway_out SHALL equal the latched pathway from C1 through DONE inclusive, and SHALL be 0 in IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 If the accepted command has rows==0 or cols==0:
- the sequencer SHALL go directly from IDLE to DONE.
- done=1 and err=1 SHALL occur at C1.
- no UB read and no switch SHALL be issued.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
- All pulses SHALL be deasserted from that edge.
- No done SHALL be produced.
- An abort sampled in DONE SHALL take priority, so done does not fire.
REQ-020 abort in IDLE SHALL be ignored.
- If abort and acceptance occur on the same edge, the command SHALL be accepted.
REQ-021 All outputs SHALL be registered, except cmd_ready, which is decoded from the state register.

Reset
REQ-022 While rst=0 the sequencer SHALL hold IDLE with all the following at 0: counters, latched fields, ub_rd_start_out, ub_ptr_select_out, ub_rd_addr_out, ub_rd_count_out, sys_switch_out, vpu_data_pathway_out, busy, done, err.
- cmd_ready SHALL be 1 during reset.
REQ-023 Reset asserted mid-command SHALL abandon the command with no done.
- After rst is deasserted, the first command SHALL be accepted on the first edge.

Verification
REQ-024 Nominal (N=2, DRAIN_CYCLES=6): w=0x10, x=0x40, b=0x30, rows=3, cols=2, pathway=4'b0101.
- Start/ptr/addr: C1 weight (ptr 1, 0x10, count 2); C5 bias (ptr 2, 0x30, count 3); C6 input (ptr 0, 0x40, count 3).
- Switch at C4; done at C16.
- busy from C1 to C16; pathway 0101 over C1..C16.
REQ-025 Back-to-back: a second command is held valid during the first -> it is accepted on the edge after the first done, with no gap or overlap of UB starts.
REQ-026 Zero-length: rows=0, cols=5 -> done=1 and err=1 at C1; no ub_rd_start_out; busy=1 only at C1.
REQ-027 Abort: abort pulsed at C3 of the REQ-024 command -> IDLE at C4; no switch, no done; cmd_ready=1 at C4.
REQ-028 Reset mid-command: rst=0 at C8 of REQ-024 -> all outputs 0 immediately; after release, a new command completes normally with REQ-024 timing.
REQ-029 Field stability: cmd_* changed every cycle after acceptance -> issued addr and count match the values at acceptance.
